// File: rtl/ldst_control_sequencer_if.sv
// Control bus between the ld/ldi/st sequencer and the datapath.
// master: the sequencer (consumes start/run/opcode/mem_ready, drives strobes).
// slave:  the datapath/memory side.
interface ldst_control_sequencer_if #(
    parameter int unsigned OPW = 5
);
    logic           start;
    logic           run;
    logic [OPW-1:0] ir_opcode;
    logic           mem_ready;

    logic PCout, IncPC, Zin, Zlowout, PCin, MARin, MDRin, MDRout, IRin, Yin;
    logic Gra, Grb, Rin, Rout, BAout, Cout, Read, Write;

    logic [OPW-1:0] alu_op;
    logic           busy;
    logic           done;
    logic           illegal;
    logic           mem_err;

    modport master (
        input  start, run, ir_opcode, mem_ready,
        output PCout, IncPC, Zin, Zlowout, PCin, MARin, MDRin, MDRout, IRin, Yin,
        output Gra, Grb, Rin, Rout, BAout, Cout, Read, Write,
        output alu_op, busy, done, illegal, mem_err
    );

    modport slave (
        output start, run, ir_opcode, mem_ready,
        input  PCout, IncPC, Zin, Zlowout, PCin, MARin, MDRin, MDRout, IRin, Yin,
        input  Gra, Grb, Rin, Rout, BAout, Cout, Read, Write,
        input  alu_op, busy, done, illegal, mem_err
    );
endinterface

// File: rtl/ldst_control_sequencer.sv
// Moore control sequencer for fetch + ld/ldi/st with memory wait states,
// continuous run mode and an illegal-opcode trap.
// Optional memory wait timeout: define SEQ_TIMEOUT_EN.
module ldst_control_sequencer #(
    parameter int unsigned    OPW     = 5,
    parameter logic [OPW-1:0] OP_LD   = 5'b00000,
    parameter logic [OPW-1:0] OP_LDI  = 5'b00001,
    parameter logic [OPW-1:0] OP_ST   = 5'b00010,
    parameter logic [OPW-1:0] ALU_ADD = 5'b00011,
    parameter int unsigned    MEM_TMO = 16
) (
    input logic                        Clock,
    input logic                        clear,
    ldst_control_sequencer_if.master   bus
);

    typedef enum logic [3:0] {
        StIdle, StT0, StT1, StT2, StDec, StT4, StT5, StT6, StT7, StDone
    } state_e;

    state_e         state_q, state_d;
    logic [OPW-1:0] op_q, op_d;
    logic           illegal_q, illegal_d;
    logic           first_q;   // current T1 cycle is the first one (T1 is entered only from T0)
    logic           is_st;
    logic           op_legal;

    assign is_st    = (op_q == OP_ST);
    assign op_legal = (bus.ir_opcode == OP_LD) || (bus.ir_opcode == OP_LDI) ||
                      (bus.ir_opcode == OP_ST);

`ifdef SEQ_TIMEOUT_EN
    localparam int unsigned CntW = (MEM_TMO > 1) ? $clog2(MEM_TMO) : 1;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            mem_err_q, mem_err_d;
    logic            in_wait;

    assign in_wait = (state_q == StT1) || (state_q == StT6 && !is_st) ||
                     (state_q == StT7 && is_st);
`else
    logic unused_tmo;
    assign unused_tmo = |MEM_TMO;
`endif

    // State and sticky flag registers
    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            state_q   <= StIdle;
            op_q      <= '0;
            illegal_q <= 1'b0;
            first_q   <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            cnt_q     <= '0;
            mem_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
            first_q   <= (state_q == StT0);
`ifdef SEQ_TIMEOUT_EN
            cnt_q     <= cnt_d;
            mem_err_q <= mem_err_d;
`endif
        end
    end

    // Next-state, opcode capture and sticky flag updates
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        illegal_d = illegal_q;
`ifdef SEQ_TIMEOUT_EN
        mem_err_d = mem_err_q;
        cnt_d     = '0;
`endif
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d   = StT0;
                    illegal_d = 1'b0;
`ifdef SEQ_TIMEOUT_EN
                    mem_err_d = 1'b0;
`endif
                end
            end
            StT0:   state_d = StT1;
            StT1:   if (bus.mem_ready) state_d = StT2;
            StT2:   state_d = StDec;
            StDec: begin
                if (op_legal) begin
                    op_d    = bus.ir_opcode;
                    state_d = StT4;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = StIdle;
                end
            end
            StT4:   state_d = StT5;
            StT5:   state_d = (op_q == OP_LDI) ? StDone : StT6;
            StT6:   if (is_st || bus.mem_ready) state_d = StT7;
            StT7:   if (!is_st || bus.mem_ready) state_d = StDone;
            StDone: state_d = bus.run ? StT0 : StIdle;
            default: state_d = StIdle;
        endcase
`ifdef SEQ_TIMEOUT_EN
        // Counter stays zero outside wait states, so each wait starts from zero
        if (in_wait && !bus.mem_ready) begin
            if (cnt_q == CntW'(MEM_TMO - 1)) begin
                mem_err_d = 1'b1;
                state_d   = StIdle;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
`endif
    end

    // Strobes decoded from registered state only
    always_comb begin
        bus.PCout   = 1'b0;
        bus.IncPC   = 1'b0;
        bus.Zin     = 1'b0;
        bus.Zlowout = 1'b0;
        bus.PCin    = 1'b0;
        bus.MARin   = 1'b0;
        bus.MDRin   = 1'b0;
        bus.MDRout  = 1'b0;
        bus.IRin    = 1'b0;
        bus.Yin     = 1'b0;
        bus.Gra     = 1'b0;
        bus.Grb     = 1'b0;
        bus.Rin     = 1'b0;
        bus.Rout    = 1'b0;
        bus.BAout   = 1'b0;
        bus.Cout    = 1'b0;
        bus.Read    = 1'b0;
        bus.Write   = 1'b0;
        bus.alu_op  = '0;
        bus.busy    = (state_q != StIdle);
        bus.done    = (state_q == StDone);
        bus.illegal = illegal_q;
`ifdef SEQ_TIMEOUT_EN
        bus.mem_err = mem_err_q;
`else
        bus.mem_err = 1'b0;
`endif
        case (state_q)
            StT0: begin
                bus.PCout = 1'b1;
                bus.MARin = 1'b1;
                bus.IncPC = 1'b1;
                bus.Zin   = 1'b1;
            end
            StT1: begin
                bus.Zlowout = first_q;
                bus.PCin    = first_q;
                bus.Read    = 1'b1;
                bus.MDRin   = 1'b1;
            end
            StT2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
            end
            StDec: begin
                bus.Grb   = 1'b1;
                bus.BAout = 1'b1;
                bus.Yin   = 1'b1;
            end
            StT4: begin
                bus.Cout   = 1'b1;
                bus.Zin    = 1'b1;
                bus.alu_op = ALU_ADD;
            end
            StT5: begin
                bus.Zlowout = 1'b1;
                if (op_q == OP_LDI) begin
                    bus.Gra = 1'b1;
                    bus.Rin = 1'b1;
                end else begin
                    bus.MARin = 1'b1;
                end
            end
            StT6: begin
                bus.MDRin = 1'b1;
                if (is_st) begin
                    bus.Gra  = 1'b1;
                    bus.Rout = 1'b1;
                end else begin
                    bus.Read = 1'b1;
                end
            end
            StT7: begin
                if (is_st) begin
                    bus.Write = 1'b1;
                end else begin
                    bus.MDRout = 1'b1;
                    bus.Gra    = 1'b1;
                    bus.Rin    = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
